// File: rtl/jtag_dtm_pkg.sv
// Shared constants for the JTAG debug transport module: TAP encodings, IR codes,
// DMI op codes, DTMCS field layout and the TAP next-state function.
package jtag_dtm_pkg;

  localparam int DMI_W = 40;

  localparam logic [3:0] TAP_EX2DR   = 4'h0;
  localparam logic [3:0] TAP_EX1DR   = 4'h1;
  localparam logic [3:0] TAP_SHDR    = 4'h2;
  localparam logic [3:0] TAP_PAUSEDR = 4'h3;
  localparam logic [3:0] TAP_SELIR   = 4'h4;
  localparam logic [3:0] TAP_UPDR    = 4'h5;
  localparam logic [3:0] TAP_CAPDR   = 4'h6;
  localparam logic [3:0] TAP_SELDR   = 4'h7;
  localparam logic [3:0] TAP_EX2IR   = 4'h8;
  localparam logic [3:0] TAP_EX1IR   = 4'h9;
  localparam logic [3:0] TAP_SHIR    = 4'hA;
  localparam logic [3:0] TAP_PAUSEIR = 4'hB;
  localparam logic [3:0] TAP_RTI     = 4'hC;
  localparam logic [3:0] TAP_UPIR    = 4'hD;
  localparam logic [3:0] TAP_CAPIR   = 4'hE;
  localparam logic [3:0] TAP_TLR     = 4'hF;

  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_DTMCS   = 5'h10;
  localparam logic [4:0] IR_DMI     = 5'h11;
  localparam logic [4:0] IR_BYPASS  = 5'h1F;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_OP_RSV   = 2'd3;

  localparam int         DTMCS_VERSION_LSB   = 0;
  localparam int         DTMCS_ABITS_LSB     = 4;
  localparam int         DTMCS_DMISTAT_LSB   = 10;
  localparam int         DTMCS_IDLE_LSB      = 12;
  localparam int         DTMCS_DMIRESET_BIT  = 16;
  localparam int         DTMCS_HARDRESET_BIT = 17;
  localparam logic [3:0] DTMCS_VERSION       = 4'd1;
  localparam logic [2:0] DTMCS_IDLE          = 3'd1;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_DTMCS  = 2'd2,
    SEL_DMI    = 2'd3
  } dr_sel_e;

  function automatic logic [3:0] tap_next(input logic [3:0] st, input logic tms);
    logic [3:0] nxt;
    case (st)
      TAP_TLR:     nxt = tms ? TAP_TLR     : TAP_RTI;
      TAP_RTI:     nxt = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELDR:   nxt = tms ? TAP_SELIR   : TAP_CAPDR;
      TAP_CAPDR:   nxt = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_SHDR:    nxt = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_EX1DR:   nxt = tms ? TAP_UPDR    : TAP_PAUSEDR;
      TAP_PAUSEDR: nxt = tms ? TAP_EX2DR   : TAP_PAUSEDR;
      TAP_EX2DR:   nxt = tms ? TAP_UPDR    : TAP_SHDR;
      TAP_UPDR:    nxt = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELIR:   nxt = tms ? TAP_TLR     : TAP_CAPIR;
      TAP_CAPIR:   nxt = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_SHIR:    nxt = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_EX1IR:   nxt = tms ? TAP_UPIR    : TAP_PAUSEIR;
      TAP_PAUSEIR: nxt = tms ? TAP_EX2IR   : TAP_PAUSEIR;
      TAP_EX2IR:   nxt = tms ? TAP_UPIR    : TAP_SHIR;
      TAP_UPIR:    nxt = tms ? TAP_SELDR   : TAP_RTI;
      default:     nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_dtm_sync.sv
// Multi-stage flop synchronizer for a vector of independent asynchronous inputs.
module jtag_dtm_sync
  import jtag_dtm_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_d;
  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  // Each stage takes the previous one; stage 0 samples the raw input
  always_comb begin
    chain_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // Synchronizer chain flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/jtag_dtm.sv
// JTAG Debug Transport Module: TAP sampled in the clk domain driving 4-phase DMI channels.
// Define JTAG_DTM_IDCODE_EN to make IR 0x01 select the IDCODE register and the reset instruction.
module jtag_dtm
  import jtag_dtm_pkg::*;
#(
  parameter int          ABITS        = 6,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0A6D,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               jtag_tck,
  input  logic               jtag_tms,
  input  logic               jtag_tdi,
  output logic               jtag_tdo,
  output logic               jtag_tdo_oe,
  output logic               dtm_dm_req,
  output logic [ABITS+33:0]  dtm_dm_data,
  input  logic               dm_dtm_ack,
  input  logic               dm_dtm_req,
  input  logic [ABITS+33:0]  dm_dtm_data,
  output logic               dtm_dm_ack
);

  localparam int         DW          = ABITS + 34;
  localparam logic [5:0] ABITS_FIELD = 6'(ABITS);
`ifdef JTAG_DTM_IDCODE_EN
  localparam logic [4:0] IR_RESET = IR_IDCODE;
`else
  localparam logic [4:0] IR_RESET = IR_BYPASS;
`endif

  logic [4:0] sync_out;
  logic       tck_sync, tms_sync, tdi_sync, ack_sync, dm_req_sync;

  jtag_dtm_sync #(
    .WIDTH  (5),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  ({jtag_tck, jtag_tms, jtag_tdi, dm_dtm_ack, dm_dtm_req}),
    .q_o  (sync_out)
  );

  assign {tck_sync, tms_sync, tdi_sync, ack_sync, dm_req_sync} = sync_out;

  logic             tck_prev_d, tck_prev_q;
  logic [3:0]       tap_d, tap_q;
  logic [4:0]       ir_d, ir_q;
  logic [4:0]       ir_sr_d, ir_sr_q;
  logic [DW-1:0]    dr_d, dr_q;
  logic             tdo_d, tdo_q;
  logic             tdo_oe_d, tdo_oe_q;
  logic [1:0]       dmistat_d, dmistat_q;
  logic             outstanding_d, outstanding_q;
  logic             abandon_d, abandon_q;
  logic [ABITS-1:0] last_addr_d, last_addr_q;
  logic [31:0]      last_rdata_d, last_rdata_q;
  logic             req_d, req_q;
  logic             req_pend_d, req_pend_q;
  logic [DW-1:0]    pend_word_d, pend_word_q;
  logic [DW-1:0]    req_word_d, req_word_q;
  logic             resp_ack_d, resp_ack_q;

  logic             tck_rise, tck_fall, dr_upd, resp_fire, dmi_op_valid;
  dr_sel_e          dr_sel;
  logic [1:0]       dmi_status;
  logic [31:0]      dtmcs_capture;
  logic [DW-1:0]    dr_capture, dr_shifted;

  assign tck_rise     = tck_sync & ~tck_prev_q;
  assign tck_fall     = ~tck_sync & tck_prev_q;
  assign dr_upd       = tck_rise & (tap_q == TAP_UPDR);
  assign resp_fire    = dm_req_sync & ~resp_ack_q;
  assign dmi_op_valid = (dr_q[1:0] == DMI_OP_READ) || (dr_q[1:0] == DMI_OP_WRITE);
  assign dmi_status   = (outstanding_q || (dmistat_q != 2'd0)) ? 2'd3 : 2'd0;
  assign dtmcs_capture = {14'd0, 1'b0, 1'b0, 1'b0, DTMCS_IDLE, dmistat_q, ABITS_FIELD, DTMCS_VERSION};

  // Instruction decode; unknown codes fall back to BYPASS
  always_comb begin
    case (ir_q)
`ifdef JTAG_DTM_IDCODE_EN
      IR_IDCODE: dr_sel = SEL_IDCODE;
`endif
      IR_DTMCS:  dr_sel = SEL_DTMCS;
      IR_DMI:    dr_sel = SEL_DMI;
      default:   dr_sel = SEL_BYPASS;
    endcase
  end

  // Capture value and one-bit shift of the selected data register (TDI enters its MSB)
  always_comb begin
    case (dr_sel)
      SEL_IDCODE: begin
        dr_capture = {{(DW-32){1'b0}}, IDCODE_VALUE};
        dr_shifted = {dr_q[DW-1:32], tdi_sync, dr_q[31:1]};
      end
      SEL_DTMCS: begin
        dr_capture = {{(DW-32){1'b0}}, dtmcs_capture};
        dr_shifted = {dr_q[DW-1:32], tdi_sync, dr_q[31:1]};
      end
      SEL_DMI: begin
        dr_capture = {last_addr_q, last_rdata_q, dmi_status};
        dr_shifted = {tdi_sync, dr_q[DW-1:1]};
      end
      default: begin
        dr_capture = '0;
        dr_shifted = {dr_q[DW-1:1], tdi_sync};
      end
    endcase
  end

  // Next state for TAP, shifters, DMI status and both handshake channels
  always_comb begin
    tck_prev_d    = tck_sync;
    tap_d         = tap_q;
    ir_d          = ir_q;
    ir_sr_d       = ir_sr_q;
    dr_d          = dr_q;
    tdo_d         = tdo_q;
    tdo_oe_d      = tdo_oe_q;
    dmistat_d     = dmistat_q;
    outstanding_d = outstanding_q;
    abandon_d     = abandon_q;
    last_addr_d   = last_addr_q;
    last_rdata_d  = last_rdata_q;
    req_d         = req_q;
    req_pend_d    = req_pend_q;
    pend_word_d   = pend_word_q;
    req_word_d    = req_word_q;
    resp_ack_d    = resp_ack_q;

    // Response goes first so a same-cycle DMI update sees outstanding already cleared
    if (resp_fire) begin
      resp_ack_d    = 1'b1;
      outstanding_d = 1'b0;
      abandon_d     = 1'b0;
      if (!abandon_q) begin
        last_addr_d  = dm_dtm_data[DW-1:34];
        last_rdata_d = dm_dtm_data[33:2];
        dmistat_d    = dmistat_q | dm_dtm_data[1:0];
      end else begin
        last_addr_d  = last_addr_q;
      end
    end else if (resp_ack_q && !dm_req_sync) begin
      resp_ack_d = 1'b0;
    end else begin
      resp_ack_d = resp_ack_q;
    end

    if (req_q) begin
      req_d = ~ack_sync;
    end else if (req_pend_q && !ack_sync) begin
      req_d      = 1'b1;
      req_word_d = pend_word_q;
      req_pend_d = 1'b0;
    end else begin
      req_d = 1'b0;
    end

    if (tck_rise) begin
      tap_d = tap_next(tap_q, tms_sync);
      case (tap_q)
        TAP_CAPIR: ir_sr_d = IR_CAPTURE;
        TAP_SHIR:  ir_sr_d = {tdi_sync, ir_sr_q[4:1]};
        TAP_UPIR:  ir_d    = ir_sr_q;
        TAP_CAPDR: dr_d    = dr_capture;
        TAP_SHDR:  dr_d    = dr_shifted;
        default:   ir_d    = ir_q;
      endcase
    end else if (tck_fall) begin
      tdo_oe_d = (tap_q == TAP_SHIR) || (tap_q == TAP_SHDR);
      if (tap_q == TAP_SHIR) begin
        tdo_d = ir_sr_q[0];
      end else if (tap_q == TAP_SHDR) begin
        tdo_d = dr_q[0];
      end else begin
        tdo_d = 1'b0;
      end
    end else begin
      tap_d = tap_q;
    end

    if (dr_upd && (dr_sel == SEL_DTMCS)) begin
      if (dr_q[DTMCS_DMIRESET_BIT] || dr_q[DTMCS_HARDRESET_BIT]) begin
        dmistat_d = 2'd0;
      end else begin
        dmistat_d = dmistat_d;
      end
      // Hard reset forgets the in-flight access; its late response is acked and dropped
      if (dr_q[DTMCS_HARDRESET_BIT]) begin
        abandon_d     = abandon_d | outstanding_d;
        outstanding_d = 1'b0;
      end else begin
        abandon_d     = abandon_d;
      end
    end else if (dr_upd && (dr_sel == SEL_DMI) && dmi_op_valid) begin
      if (outstanding_d) begin
        dmistat_d = 2'd3;
      end else if (dmistat_d == 2'd0) begin
        pend_word_d   = dr_q;
        req_pend_d    = 1'b1;
        outstanding_d = 1'b1;
      end else begin
        req_pend_d    = req_pend_d;
      end
    end else begin
      dmistat_d = dmistat_d;
    end

    if (tap_q == TAP_TLR) begin
      ir_d = IR_RESET;
    end else begin
      ir_d = ir_d;
    end
  end

  // State registers; reset drops both handshakes and parks the TAP in Test-Logic-Reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tck_prev_q    <= 1'b0;
      tap_q         <= TAP_TLR;
      ir_q          <= IR_RESET;
      ir_sr_q       <= 5'd0;
      dr_q          <= '0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
      dmistat_q     <= 2'd0;
      outstanding_q <= 1'b0;
      abandon_q     <= 1'b0;
      last_addr_q   <= '0;
      last_rdata_q  <= 32'd0;
      req_q         <= 1'b0;
      req_pend_q    <= 1'b0;
      pend_word_q   <= '0;
      req_word_q    <= '0;
      resp_ack_q    <= 1'b0;
    end else begin
      tck_prev_q    <= tck_prev_d;
      tap_q         <= tap_d;
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      dr_q          <= dr_d;
      tdo_q         <= tdo_d;
      tdo_oe_q      <= tdo_oe_d;
      dmistat_q     <= dmistat_d;
      outstanding_q <= outstanding_d;
      abandon_q     <= abandon_d;
      last_addr_q   <= last_addr_d;
      last_rdata_q  <= last_rdata_d;
      req_q         <= req_d;
      req_pend_q    <= req_pend_d;
      pend_word_q   <= pend_word_d;
      req_word_q    <= req_word_d;
      resp_ack_q    <= resp_ack_d;
    end
  end

  assign jtag_tdo    = tdo_q;
  assign jtag_tdo_oe = tdo_oe_q;
  assign dtm_dm_req  = req_q;
  assign dtm_dm_data = req_word_q;
  assign dtm_dm_ack  = resp_ack_q;

endmodule
